// File: rtl/lc4_div_pkg.sv
// lc4_div_pkg: shared constants, FSM state encoding and sizing helpers for the
// LC4 sequential divider.
//   DIV_W      : datapath width (16-bit unsigned arithmetic)
//   state_e    : divider FSM states
//   div_steps  : number of clock cycles (N) needed for ITERS_PER_CYCLE
//   div_cnt_w  : width of the iteration counter (at least 1 bit)
package lc4_div_pkg;

  localparam int DIV_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int div_steps(input int iters);
    return DIV_W / iters;
  endfunction

  function automatic int div_cnt_w(input int iters);
    int n;
    n = DIV_W / iters;
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lc4_divider_one_iter.sv
// lc4_divider_one_iter: one combinational restoring-division step.
//   i_dividend  : dividend bits still to be shifted in (MSB consumed here)
//   i_divisor   : divisor
//   i_remainder : partial remainder so far
//   i_quotient  : partial quotient so far
//   o_dividend  : dividend shifted left by one
//   o_remainder : updated partial remainder
//   o_quotient  : quotient shifted left with the new quotient bit
module lc4_divider_one_iter
  import lc4_div_pkg::*;
(
  input  logic [DIV_W-1:0] i_dividend,
  input  logic [DIV_W-1:0] i_divisor,
  input  logic [DIV_W-1:0] i_remainder,
  input  logic [DIV_W-1:0] i_quotient,
  output logic [DIV_W-1:0] o_dividend,
  output logic [DIV_W-1:0] o_remainder,
  output logic [DIV_W-1:0] o_quotient
);

  // The shifted remainder keeps its carry bit so that divisors >= 0x8000
  // compare correctly.
  logic [DIV_W:0]   rem_shift;
  logic [DIV_W-1:0] rem_sub;
  logic             ge;

  always_comb begin
    rem_shift = {i_remainder, i_dividend[DIV_W-1]};
    ge        = (rem_shift >= {1'b0, i_divisor});
    // When ge holds the true difference is < 2^16, so the low bits suffice.
    rem_sub   = rem_shift[DIV_W-1:0] - i_divisor;
    o_dividend  = i_dividend << 1;
    o_quotient  = (i_quotient << 1) | {{(DIV_W-1){1'b0}}, ge};
    o_remainder = ge ? rem_sub : rem_shift[DIV_W-1:0];
  end

endmodule

// File: rtl/lc4_divider_seq.sv
// lc4_divider_seq: multi-cycle 16-bit unsigned divider shared by two
// requesters with round-robin arbitration and a valid/ready result handshake.
// Divide-by-zero returns quotient = 0 and remainder = 0.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   i_req_valid[1:0]            : per-requester request valid
//   i_dividend_k, i_divisor_k   : requester k operands
//   o_req_ready[1:0]            : one-hot grant (only in IDLE)
//   o_resp_valid, o_resp_id     : result valid and owning requester
//   o_quotient, o_remainder     : registered result
//   i_resp_ready                : consumer accepts the result
//   o_busy                      : high while calculating or holding a result
module lc4_divider_seq
  import lc4_div_pkg::*;
#(
  parameter int ITERS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       i_req_valid,
  input  logic [DIV_W-1:0] i_dividend_0,
  input  logic [DIV_W-1:0] i_divisor_0,
  input  logic [DIV_W-1:0] i_dividend_1,
  input  logic [DIV_W-1:0] i_divisor_1,
  output logic [1:0]       o_req_ready,
  output logic             o_resp_valid,
  output logic             o_resp_id,
  output logic [DIV_W-1:0] o_quotient,
  output logic [DIV_W-1:0] o_remainder,
  input  logic             i_resp_ready,
  output logic             o_busy
);

  localparam int N     = div_steps(ITERS_PER_CYCLE);
  localparam int CNT_W = div_cnt_w(ITERS_PER_CYCLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q, id_d;
  logic [DIV_W-1:0] dividend_q, dividend_d;
  logic [DIV_W-1:0] divisor_q, divisor_d;
  logic [DIV_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resp_id_q, resp_id_d;
  logic [DIV_W-1:0] quotient_q, quotient_d;
  logic [DIV_W-1:0] remainder_q, remainder_d;
  logic [1:0]       grant;

  // Combinational chain of ITERS_PER_CYCLE division steps fed by the
  // working registers; element 0 is the register value, the last element
  // is what gets written back on the clock edge.
  logic [DIV_W-1:0] chain_dvd [ITERS_PER_CYCLE+1];
  logic [DIV_W-1:0] chain_rem [ITERS_PER_CYCLE+1];
  logic [DIV_W-1:0] chain_quo [ITERS_PER_CYCLE+1];

  assign chain_dvd[0] = dividend_q;
  assign chain_rem[0] = rem_q;
  assign chain_quo[0] = quo_q;

  generate
    for (genvar gi = 0; gi < ITERS_PER_CYCLE; gi++) begin : g_iter
      lc4_divider_one_iter u_iter (
        .i_dividend  (chain_dvd[gi]),
        .i_divisor   (divisor_q),
        .i_remainder (chain_rem[gi]),
        .i_quotient  (chain_quo[gi]),
        .o_dividend  (chain_dvd[gi+1]),
        .o_remainder (chain_rem[gi+1]),
        .o_quotient  (chain_quo[gi+1])
      );
    end
  endgenerate

  // Round-robin arbiter: a contested grant goes to the requester that was
  // not served last.
  always_comb begin
    grant = 2'b00;
    if (state_q == IDLE) begin
      case (i_req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    dividend_d   = dividend_q;
    divisor_d    = divisor_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    cnt_d        = cnt_q;
    resp_id_d    = resp_id_q;
    quotient_d   = quotient_q;
    remainder_d  = remainder_q;
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          id_d         = grant[1];
          last_grant_d = grant[1];
          dividend_d   = grant[1] ? i_dividend_1 : i_dividend_0;
          divisor_d    = grant[1] ? i_divisor_1  : i_divisor_0;
          rem_d        = '0;
          quo_d        = '0;
          cnt_d        = '0;
          state_d      = CALC;
        end
      end
      CALC: begin
        dividend_d = chain_dvd[ITERS_PER_CYCLE];
        rem_d      = chain_rem[ITERS_PER_CYCLE];
        quo_d      = chain_quo[ITERS_PER_CYCLE];
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d   = DONE;
          resp_id_d = id_q;
          // A zero divisor would leave an all-ones quotient; discard it.
          if (divisor_q == '0) begin
            quotient_d  = '0;
            remainder_d = '0;
          end else begin
            quotient_d  = chain_quo[ITERS_PER_CYCLE];
            remainder_d = chain_rem[ITERS_PER_CYCLE];
          end
        end
      end
      DONE: begin
        if (i_resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      dividend_q   <= '0;
      divisor_q    <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      cnt_q        <= '0;
      resp_id_q    <= 1'b0;
      quotient_q   <= '0;
      remainder_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      dividend_q   <= dividend_d;
      divisor_q    <= divisor_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      cnt_q        <= cnt_d;
      resp_id_q    <= resp_id_d;
      quotient_q   <= quotient_d;
      remainder_q  <= remainder_d;
    end
  end

  assign o_req_ready  = grant;
  assign o_resp_valid = (state_q == DONE);
  assign o_busy       = (state_q == CALC) || (state_q == DONE);
  assign o_resp_id    = resp_id_q;
  assign o_quotient   = quotient_q;
  assign o_remainder  = remainder_q;

endmodule

// File: tb/tb_lc4_divider_seq.sv
// tb_lc4_divider_seq: self-checking bench for lc4_divider_seq. Three
// instances (ITERS_PER_CYCLE = 1, 4, 16) share clock and reset; directed
// scenarios run on the first, randomized operands run on all three and are
// compared against plain / and % with the zero-divisor rule.
module tb_lc4_divider_seq;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid  [3];
  logic [15:0] dvd0       [3];
  logic [15:0] dvs0       [3];
  logic [15:0] dvd1       [3];
  logic [15:0] dvs1       [3];
  logic        resp_ready [3];
  logic [1:0]  req_ready  [3];
  logic        resp_valid [3];
  logic        resp_id    [3];
  logic [15:0] quo        [3];
  logic [15:0] rem        [3];
  logic        busy       [3];

  int n_checks = 0;
  int n_errors = 0;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      lc4_divider_seq #(.ITERS_PER_CYCLE(1 << (2 * gi))) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (req_valid[gi]),
        .i_dividend_0 (dvd0[gi]),
        .i_divisor_0  (dvs0[gi]),
        .i_dividend_1 (dvd1[gi]),
        .i_divisor_1  (dvs1[gi]),
        .o_req_ready  (req_ready[gi]),
        .o_resp_valid (resp_valid[gi]),
        .o_resp_id    (resp_id[gi]),
        .o_quotient   (quo[gi]),
        .o_remainder  (rem[gi]),
        .i_resp_ready (resp_ready[gi]),
        .o_busy       (busy[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int k, input int port, input logic [15:0] a, input logic [15:0] b);
    if (port == 0) begin
      dvd0[k] = a;
      dvs0[k] = b;
    end else begin
      dvd1[k] = a;
      dvs1[k] = b;
    end
    req_valid[k][port] = 1'b1;
  endtask

  // Wait (bounded) until requester 'port' is granted, then step through the
  // accept edge and drop its valid.
  task automatic wait_grant(input int k, input int port);
    int c;
    c = 0;
    #1;
    while (!req_ready[k][port] && c < 64) begin
      tick();
      #1;
      c++;
    end
    check("grant_wait", 32'(c < 64), 1);
    tick();
    req_valid[k][port] = 1'b0;
  endtask

  // Called right after the accept edge: measures latency, checks the result,
  // holds it for 'stall' cycles, then completes the handshake.
  task automatic collect(input int k, input int exp_id, input logic [15:0] exp_q,
                         input logic [15:0] exp_r, input int stall);
    int lat;
    int n;
    lat = 0;
    n = 16 >> (2 * k);
    check("busy_calc", busy[k], 1);
    while (!resp_valid[k] && lat < 40) begin
      tick();
      lat++;
    end
    check("latency", lat, n);
    check("resp_id", resp_id[k], exp_id);
    check("quotient", quo[k], exp_q);
    check("remainder", rem[k], exp_r);
    for (int s = 0; s < stall; s++) begin
      tick();
      check("stall_valid", resp_valid[k], 1);
      check("stall_busy", busy[k], 1);
      check("stall_id", resp_id[k], exp_id);
      check("stall_q", quo[k], exp_q);
      check("stall_r", rem[k], exp_r);
      check("stall_req_ready", req_ready[k], 0);
    end
    resp_ready[k] = 1'b1;
    #1;
    check("handshake_req_ready", req_ready[k], 0);
    tick();
    resp_ready[k] = 1'b0;
    #1;
    check("idle_valid", resp_valid[k], 0);
    check("idle_busy", busy[k], 0);
  endtask

  task automatic check_zero_outputs(input int k, input string tag);
    check({tag, "_valid"}, resp_valid[k], 0);
    check({tag, "_busy"}, busy[k], 0);
    check({tag, "_id"}, resp_id[k], 0);
    check({tag, "_q"}, quo[k], 0);
    check({tag, "_r"}, rem[k], 0);
    check({tag, "_ready"}, req_ready[k], 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int seen;
    int port;
    int sel;
    int stall;
    logic [31:0] rnd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] eq;
    logic [15:0] er;

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid[k]  = 2'b00;
      dvd0[k]       = '0;
      dvs0[k]       = '0;
      dvd1[k]       = '0;
      dvs1[k]       = '0;
      resp_ready[k] = 1'b0;
    end
    tick();
    tick();
    for (int k = 0; k < 3; k++) check_zero_outputs(k, "reset");
    rst_n = 1'b1;
    tick();

    // Contested requests right after reset: port0 wins, then port1,
    // then port0 again.
    drive_req(0, 0, 16'h0064, 16'h000A);
    drive_req(0, 1, 16'hFFFF, 16'h0001);
    #1;
    check("rr_first", req_ready[0], 2'b01);
    wait_grant(0, 0);
    collect(0, 0, 16'h000A, 16'h0000, 0);
    #1;
    check("rr_second", req_ready[0], 2'b10);
    wait_grant(0, 1);
    collect(0, 1, 16'hFFFF, 16'h0000, 0);
    drive_req(0, 0, 16'h0064, 16'h000A);
    drive_req(0, 1, 16'hFFFF, 16'h0001);
    #1;
    check("rr_third", req_ready[0], 2'b01);
    wait_grant(0, 0);
    collect(0, 0, 16'h000A, 16'h0000, 0);
    wait_grant(0, 1);
    collect(0, 1, 16'hFFFF, 16'h0000, 0);

    // Basic divide and divide-by-zero.
    drive_req(0, 0, 16'h0007, 16'h0002);
    wait_grant(0, 0);
    collect(0, 0, 16'h0003, 16'h0001, 0);
    drive_req(0, 1, 16'hBEEF, 16'h0000);
    wait_grant(0, 1);
    collect(0, 1, 16'h0000, 16'h0000, 0);

    // Consumer stall with another request pending: no grant while holding.
    drive_req(0, 0, 16'h0100, 16'h0003);
    wait_grant(0, 0);
    drive_req(0, 1, 16'h0009, 16'h0003);
    collect(0, 0, 16'h0055, 16'h0001, 5);
    #1;
    check("after_stall_grant", req_ready[0], 2'b10);
    wait_grant(0, 1);
    collect(0, 1, 16'h0003, 16'h0000, 0);

    // Reset in the middle of a calculation drops the operation.
    drive_req(0, 0, 16'h1234, 16'h0011);
    wait_grant(0, 0);
    repeat (8) tick();
    rst_n = 1'b0;
    #1;
    check_zero_outputs(0, "midreset");
    tick();
    tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      tick();
      if (resp_valid[0]) seen = 1;
    end
    check("no_resp_after_reset", seen, 0);
    drive_req(0, 0, 16'h1234, 16'h0011);
    wait_grant(0, 0);
    collect(0, 0, 16'h0112, 16'h0002, 0);

    // Randomized operands on every configuration.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 1000; i++) begin
        port = $urandom_range(0, 1);
        rnd  = $urandom;
        a    = rnd[15:0];
        sel  = $urandom_range(0, 9);
        rnd  = $urandom;
        if (sel == 0)      b = 16'h0000;
        else if (sel < 4)  b = 16'($urandom_range(1, 255));
        else if (sel == 4) b = 16'h8000 | rnd[15:0];
        else               b = rnd[15:0];
        if (b == 16'h0000) begin
          eq = 16'h0000;
          er = 16'h0000;
        end else begin
          eq = a / b;
          er = a % b;
        end
        stall = $urandom_range(0, 2);
        drive_req(k, port, a, b);
        wait_grant(k, port);
        collect(k, port, eq, er, stall);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
